// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter and the MEM-stage width controller.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FORCE   = 2'd1,
      ST_DBG_RSP = 2'd2
   } arb_state_e;

   localparam logic [2:0] SIZE_WORD = 3'b100;
   localparam logic [2:0] SIZE_HALF = 3'b010;
   localparam logic [2:0] SIZE_BYTE = 3'b001;

   // Keeps only the low lanes belonging to an access of the given size.
   function automatic logic [31:0] sizeMask(input logic [2:0] size);
      logic [31:0] mask;
      case (size)
         SIZE_WORD: mask = 32'hFFFF_FFFF;
         SIZE_HALF: mask = 32'h0000_FFFF;
         SIZE_BYTE: mask = 32'h0000_00FF;
         default:   mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundles the CPU MEM-stage, debug-read and BRAM signals around the arbiter.
interface data_mem_arbiter_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 9
);
   logic               cpu_mem_read;
   logic               cpu_mem_write;
   logic [2:0]         cpu_size;
   logic [NB_ADDR-1:0] cpu_addr;
   logic [NB_DATA-1:0] cpu_wdata;
   logic [NB_DATA-1:0] cpu_rdata;
   logic               cpu_stall;
   logic               cpu_misalign;
   logic               dbg_req;
   logic [NB_ADDR-1:0] dbg_addr;
   logic               dbg_ack;
   logic [NB_DATA-1:0] dbg_rdata;
   logic               mem_en;
   logic [3:0]         mem_we;
   logic [NB_ADDR-3:0] mem_addr;
   logic [NB_DATA-1:0] mem_wdata;
   logic [NB_DATA-1:0] mem_rdata;

   modport slave (
      input  cpu_mem_read, cpu_mem_write, cpu_size, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall, cpu_misalign,
      input  dbg_req, dbg_addr,
      output dbg_ack, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_mem_read, cpu_mem_write, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall, cpu_misalign,
      output dbg_req, dbg_addr,
      input  dbg_ack, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter_mem_lane_steer.sv
// Byte-enable generation and write-lane steering for one CPU access.
module mem_lane_steer
   import data_mem_arbiter_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [2:0]         size_i,
   input  logic [1:0]         lo_i,
   input  logic [NB_DATA-1:0] wdata_i,
   output logic [3:0]         we_o,
   output logic [NB_DATA-1:0] wdata_o,
   output logic               misalign_o,
   output logic               legal_o
);

   // legal_o marks a recognised, aligned size; unknown size codes are neither legal nor misaligned.
   always_comb begin
      we_o       = 4'b0000;
      misalign_o = 1'b0;
      legal_o    = 1'b0;
      case (size_i)
         SIZE_BYTE: begin
            we_o    = 4'b0001 << lo_i;
            legal_o = 1'b1;
         end
         SIZE_HALF: begin
            if (lo_i[0]) begin
               misalign_o = 1'b1;
            end else begin
               we_o    = 4'b0011 << {lo_i[1], 1'b0};
               legal_o = 1'b1;
            end
         end
         SIZE_WORD: begin
            if (lo_i != 2'b00) begin
               misalign_o = 1'b1;
            end else begin
               we_o    = 4'b1111;
               legal_o = 1'b1;
            end
         end
         default: begin
            we_o = 4'b0000;
         end
      endcase
   end

   assign wdata_o = wdata_i << {lo_i, 3'b000};

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data BRAM between the MEM stage (priority) and the read-only debug unit,
// forcing a one-cycle CPU stall when a debug read has been starved for MAX_WAIT cycles.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_ADDR  = 9,
   parameter int MAX_WAIT = 4,
   parameter int NB_WAIT  = 3
) (
   input  logic          i_clock,
   input  logic          i_reset,
   data_mem_arbiter_if.slave bus
);

   arb_state_e         state_q, state_d;
   logic [NB_WAIT-1:0] waitCnt_q, waitCnt_d;
   logic               dbgAck_q, dbgAck_d;
   logic [NB_DATA-1:0] dbgRdata_q, dbgRdata_d;
   logic [1:0]         rdLo_q, rdLo_d;
   logic [2:0]         rdSize_q, rdSize_d;

   logic [3:0]         steerWe;
   logic [NB_DATA-1:0] steerWdata;
   logic               steerMisalign;
   logic               steerLegal;

   logic               cpuReq;
   logic               cpuAccess;
   logic               dbgPending;
   logic               cpuGrant;
   logic               memEn;
   logic [3:0]         memWe;
   logic [NB_ADDR-3:0] memAddr;
   logic [NB_DATA-1:0] memWdata;
   logic               cpuStall;
   logic               unusedDbgLo;

   mem_lane_steer #(.NB_DATA(NB_DATA)) u_steer (
      .size_i     (bus.cpu_size),
      .lo_i       (bus.cpu_addr[1:0]),
      .wdata_i    (bus.cpu_wdata),
      .we_o       (steerWe),
      .wdata_o    (steerWdata),
      .misalign_o (steerMisalign),
      .legal_o    (steerLegal)
   );

   assign cpuReq      = bus.cpu_mem_read | bus.cpu_mem_write;
   assign cpuAccess   = cpuReq & steerLegal & ~steerMisalign;
   assign dbgPending  = bus.dbg_req & ~dbgAck_q;
   assign unusedDbgLo = ^bus.dbg_addr[1:0];

   // Debug reads only get the BRAM when the CPU is idle, or in the forced slot after starvation.
   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      dbgAck_d   = 1'b0;
      dbgRdata_d = dbgRdata_q;
      rdLo_d     = 2'b00;
      rdSize_d   = 3'b000;
      cpuGrant   = 1'b0;
      cpuStall   = 1'b0;
      memEn      = 1'b0;
      memWe      = 4'b0000;
      memAddr    = '0;
      memWdata   = '0;
      case (state_q)
         ST_IDLE: begin
            if (cpuAccess) begin
               cpuGrant = 1'b1;
               if (dbgPending) begin
                  waitCnt_d = waitCnt_q + 1'b1;
                  if (waitCnt_q == NB_WAIT'(MAX_WAIT - 1)) begin
                     state_d = ST_FORCE;
                  end
               end
            end else if (dbgPending) begin
               memEn     = 1'b1;
               memAddr   = bus.dbg_addr[NB_ADDR-1:2];
               state_d   = ST_DBG_RSP;
               waitCnt_d = '0;
            end
         end
         ST_FORCE: begin
            cpuStall  = 1'b1;
            memEn     = 1'b1;
            memAddr   = bus.dbg_addr[NB_ADDR-1:2];
            state_d   = ST_DBG_RSP;
            waitCnt_d = '0;
         end
         ST_DBG_RSP: begin
            dbgRdata_d = bus.mem_rdata;
            dbgAck_d   = 1'b1;
            cpuGrant   = cpuAccess;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (cpuGrant) begin
         memEn    = 1'b1;
         memAddr  = bus.cpu_addr[NB_ADDR-1:2];
         memWe    = bus.cpu_mem_write ? steerWe : 4'b0000;
         memWdata = steerWdata;
         if (bus.cpu_mem_read) begin
            rdLo_d   = bus.cpu_addr[1:0];
            rdSize_d = bus.cpu_size;
         end
      end
   end

   // A reset mid-transaction drops the debug read silently; the debug unit reissues it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         waitCnt_q  <= '0;
         dbgAck_q   <= 1'b0;
         dbgRdata_q <= '0;
         rdLo_q     <= 2'b00;
         rdSize_q   <= 3'b000;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         dbgAck_q   <= dbgAck_d;
         dbgRdata_q <= dbgRdata_d;
         rdLo_q     <= rdLo_d;
         rdSize_q   <= rdSize_d;
      end
   end

   assign bus.cpu_rdata    = (bus.mem_rdata >> {rdLo_q, 3'b000}) & sizeMask(rdSize_q);
   assign bus.cpu_stall    = cpuStall;
   assign bus.cpu_misalign = cpuReq & steerMisalign;
   assign bus.dbg_ack      = dbgAck_q;
   assign bus.dbg_rdata    = dbgRdata_q;
   assign bus.mem_en       = memEn;
   assign bus.mem_we       = memWe;
   assign bus.mem_addr     = memAddr;
   assign bus.mem_wdata    = memWdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: lane-steering vector table plus multi-cycle arbitration sequences.
module tb_data_mem_arbiter;
   import data_mem_arbiter_pkg::*;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  size;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic        expEn;
      logic [3:0]  expWe;
      logic [6:0]  expAddr;
      logic [31:0] expWdata;
      logic        expMis;
   } vec_t;

   typedef struct {
      logic [2:0]  size;
      logic [8:0]  addr;
      logic [31:0] expData;
   } rdvec_t;

   logic clock = 1'b0;
   logic reset;
   int   passCount = 0;
   int   checkCount = 0;
   int   ackSeen;

   logic [31:0] memModel [0:127];
   vec_t        vecs [13];
   rdvec_t      rdVecs [5];

   always #5 clock = ~clock;

   data_mem_arbiter_if #(.NB_DATA(32), .NB_ADDR(9)) bus();

   data_mem_arbiter #(
      .NB_DATA(32), .NB_ADDR(9), .MAX_WAIT(4), .NB_WAIT(3)
   ) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus)
   );

   // Behavioural BRAM: read-first, one-cycle read latency, preloaded during reset.
   always @(posedge clock) begin
      if (reset) begin
         memModel[1] <= 32'h1122_3344;
         memModel[4] <= 32'hDEAD_BEEF;
      end else if (bus.mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_we[b]) memModel[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
         bus.mem_rdata <= memModel[bus.mem_addr];
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] size,
                                input logic [8:0] addr, input logic [31:0] wdata);
      bus.cpu_mem_read  = rd;
      bus.cpu_mem_write = wr;
      bus.cpu_size      = size;
      bus.cpu_addr      = addr;
      bus.cpu_wdata     = wdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   function automatic logic [31:0] laneMask(input logic [3:0] we);
      return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, SIZE_BYTE, 9'h040, 32'h0000_00AB, 1'b1, 4'b0001, 7'd16, 32'h0000_00AB, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, SIZE_BYTE, 9'h041, 32'h0000_00CD, 1'b1, 4'b0010, 7'd16, 32'h0000_CD00, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, SIZE_BYTE, 9'h042, 32'h0000_0012, 1'b1, 4'b0100, 7'd16, 32'h0012_0000, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, SIZE_HALF, 9'h046, 32'h0000_BEEF, 1'b1, 4'b1100, 7'd17, 32'hBEEF_0000, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, SIZE_HALF, 9'h044, 32'h0000_1234, 1'b1, 4'b0011, 7'd17, 32'h0000_1234, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, SIZE_WORD, 9'h048, 32'hCAFE_F00D, 1'b1, 4'b1111, 7'd18, 32'hCAFE_F00D, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, SIZE_HALF, 9'h047, 32'h0000_5555, 1'b0, 4'b0000, 7'd0,  32'h0,         1'b1};
      vecs[7]  = '{1'b0, 1'b1, SIZE_WORD, 9'h04A, 32'h6666_6666, 1'b0, 4'b0000, 7'd0,  32'h0,         1'b1};
      vecs[8]  = '{1'b1, 1'b0, SIZE_WORD, 9'h04C, 32'h0,         1'b1, 4'b0000, 7'd19, 32'h0,         1'b0};
      vecs[9]  = '{1'b0, 1'b1, 3'b011,    9'h050, 32'h7777_7777, 1'b0, 4'b0000, 7'd0,  32'h0,         1'b0};
      vecs[10] = '{1'b0, 1'b1, 3'b000,    9'h050, 32'h7777_7777, 1'b0, 4'b0000, 7'd0,  32'h0,         1'b0};
      vecs[11] = '{1'b0, 1'b0, SIZE_WORD, 9'h050, 32'h7777_7777, 1'b0, 4'b0000, 7'd0,  32'h0,         1'b0};
      vecs[12] = '{1'b1, 1'b0, SIZE_BYTE, 9'h04F, 32'h0,         1'b1, 4'b0000, 7'd19, 32'h0,         1'b0};

      rdVecs[0] = '{SIZE_HALF, 9'h040, 32'h0000_CDAB};
      rdVecs[1] = '{SIZE_BYTE, 9'h042, 32'h0000_0012};
      rdVecs[2] = '{SIZE_BYTE, 9'h041, 32'h0000_00CD};
      rdVecs[3] = '{SIZE_HALF, 9'h046, 32'h0000_BEEF};
      rdVecs[4] = '{SIZE_WORD, 9'h048, 32'hCAFE_F00D};

      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      bus.dbg_req  = 1'b0;
      bus.dbg_addr = 9'h000;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      #1;
      checkOutput("rst_stall", bus.cpu_stall, 32'd0);
      checkOutput("rst_ack", bus.dbg_ack, 32'd0);
      checkOutput("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
      checkOutput("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      checkOutput("rst_mem_en", bus.mem_en, 32'd0);
      checkOutput("rst_misalign", bus.cpu_misalign, 32'd0);

      // Debug read with the CPU idle: enable in cycle 0, ack in cycle 2
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         bus.dbg_req  = (c < 3);
         bus.dbg_addr = 9'h010;
         #1;
         if (c == 0) begin
            checkOutput("dbg_en_c0", bus.mem_en, 32'd1);
            checkOutput("dbg_addr_c0", bus.mem_addr, 32'd4);
            checkOutput("dbg_we_c0", bus.mem_we, 32'd0);
         end
         checkOutput($sformatf("dbg_ack_c%0d", c), bus.dbg_ack, (c == 2));
         if (c == 2) checkOutput("dbg_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
      end

      // Held request: one ack per request; second request after deassert/reassert
      ackSeen = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clock);
         bus.dbg_req  = (c <= 2) || (c >= 4 && c <= 6);
         bus.dbg_addr = (c <= 2) ? 9'h006 : 9'h010;
         #1;
         if (bus.dbg_ack) ackSeen++;
         checkOutput($sformatf("hold_ack_c%0d", c), bus.dbg_ack, (c == 2) || (c == 6));
         if (c == 2) begin
            checkOutput("hold_en_at_ack", bus.mem_en, 32'd0);
            checkOutput("hold_rdata1", bus.dbg_rdata, 32'h1122_3344);
         end
         if (c == 6) checkOutput("hold_rdata2", bus.dbg_rdata, 32'hDEAD_BEEF);
      end
      checkOutput("hold_ack_count", ackSeen, 32'd2);

      // Byte store to 0x13 then half load from 0x12
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, SIZE_BYTE, 9'h013, 32'h0000_00AB);
      #1;
      checkOutput("stb_we", bus.mem_we, 32'h8);
      checkOutput("stb_lane3", {24'h0, bus.mem_wdata[31:24]}, 32'hAB);
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, SIZE_HALF, 9'h012, 32'h0);
      #1;
      checkOutput("ldh_en", bus.mem_en, 32'd1);
      checkOutput("ldh_addr", bus.mem_addr, 32'd4);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      #1;
      checkOutput("ldh_rdata", bus.cpu_rdata, 32'h0000_ABAD);

      // Starvation: CPU busy every cycle, forced stall at cycle 4, ack at cycle 6
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         applyStimulus(1'b1, 1'b0, SIZE_WORD, 9'h020, 32'h0);
         bus.dbg_req  = (c < 7);
         bus.dbg_addr = 9'h010;
         #1;
         checkOutput($sformatf("starve_stall_c%0d", c), bus.cpu_stall, (c == 4));
         checkOutput($sformatf("starve_ack_c%0d", c), bus.dbg_ack, (c == 6));
         checkOutput($sformatf("starve_addr_c%0d", c), bus.mem_addr, (c == 4) ? 32'd4 : 32'd8);
         if (c == 6) checkOutput("starve_rdata", bus.dbg_rdata, 32'hABAD_BEEF);
      end
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      bus.dbg_req = 1'b0;

      // Misaligned stores are suppressed and leave memory intact
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, SIZE_WORD, 9'h006, 32'hFFFF_FFFF);
      #1;
      checkOutput("misw_flag", bus.cpu_misalign, 32'd1);
      checkOutput("misw_en", bus.mem_en, 32'd0);
      checkOutput("misw_we", bus.mem_we, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, SIZE_HALF, 9'h005, 32'hFFFF_FFFF);
      #1;
      checkOutput("mish_flag", bus.cpu_misalign, 32'd1);
      checkOutput("mish_en", bus.mem_en, 32'd0);
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, SIZE_WORD, 9'h004, 32'h0);
      #1;
      checkOutput("mis_ld_flag", bus.cpu_misalign, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      #1;
      checkOutput("mis_mem_intact", bus.cpu_rdata, 32'h1122_3344);

      // Lane-steering vector table
      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         #1;
         checkOutput($sformatf("vec%0d_en", i), bus.mem_en, vecs[i].expEn);
         checkOutput($sformatf("vec%0d_we", i), bus.mem_we, vecs[i].expWe);
         checkOutput($sformatf("vec%0d_mis", i), bus.cpu_misalign, vecs[i].expMis);
         if (vecs[i].expEn) checkOutput($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].expAddr);
         if (vecs[i].expWe != 4'b0000)
            checkOutput($sformatf("vec%0d_wdata", i), bus.mem_wdata & laneMask(vecs[i].expWe), vecs[i].expWdata);
      end

      // Read back what the table stored, exercising read lane alignment
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         applyStimulus(1'b1, 1'b0, rdVecs[i].size, rdVecs[i].addr, 32'h0);
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
         #1;
         checkOutput($sformatf("rd%0d_data", i), bus.cpu_rdata, rdVecs[i].expData);
      end

      // Reset for two cycles in the middle of a forced debug slot
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         applyStimulus(1'b1, 1'b0, SIZE_WORD, 9'h020, 32'h0);
         bus.dbg_req  = 1'b1;
         bus.dbg_addr = 9'h010;
         #1;
         if (c == 4) checkOutput("rstf_in_force", bus.cpu_stall, 32'd1);
      end
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      bus.dbg_req = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("rstf_stall", bus.cpu_stall, 32'd0);
      checkOutput("rstf_ack", bus.dbg_ack, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      ackSeen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         #1;
         if (bus.dbg_ack) ackSeen++;
      end
      checkOutput("rstf_no_ack", ackSeen, 32'd0);
      checkOutput("rstf_dbg_rdata", bus.dbg_rdata, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
